// File: rtl/env_state_seq.sv
// Voice sequencer and per-voice envelope state store for the time-multiplexed envelope engine.
// Reads one voice per cycle, presents it to the engine, and writes the engine result back LAT cycles later.
module env_state_seq #(
    parameter int NV  = 8,
    parameter int VSZ = 3,
    parameter int LAT = 5,
    parameter int CSZ = 15,
    parameter int ASZ = 9
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           run,
    input  logic           kc_we,
    input  logic [VSZ-1:0] kc_voice,
    input  logic           kc_on,
    output logic           e_active,
    output logic           e_trig,
    output logic [1:0]     e_st,
    output logic [CSZ-1:0] e_ctr,
    output logic [ASZ-1:0] e_val,
    input  logic [1:0]     o_st,
    input  logic [CSZ-1:0] o_ctr,
    input  logic [ASZ-1:0] o_val,
    input  logic [ASZ-1:0] atten,
    output logic           att_vld,
    output logic [VSZ-1:0] att_voice,
    output logic [ASZ-1:0] atten_out,
    output logic           busy
);

    localparam int WW = 2 + CSZ + ASZ;

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t         state;
    logic [VSZ-1:0] init_ctr;
    logic [VSZ-1:0] issue_ctr;
    logic           issue;

    logic [WW-1:0]  mem [NV];
    logic           we;
    logic [VSZ-1:0] wa;
    logic [WW-1:0]  wd;

    logic [NV-1:0]  active;
    logic [NV-1:0]  pend;
    logic [NV-1:0]  kc_sel;
    logic [NV-1:0]  rd_sel;

    logic [LAT:0]   dl_vld;
    logic [VSZ-1:0] dl_voice [LAT+1];

    assign issue = (state == S_RUN) && run;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= S_INIT;
            init_ctr  <= '0;
            issue_ctr <= '0;
            busy      <= 1'b1;
        end else begin
            case (state)
                S_INIT: begin
                    init_ctr <= init_ctr + 1'b1;
                    if (init_ctr == VSZ'(NV - 1)) begin
                        state <= S_RUN;
                        busy  <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (run) begin
                        issue_ctr <= issue_ctr + 1'b1;
                    end
                end
                default: state <= S_INIT;
            endcase
        end
    end

    // Init sweep and writeback share the single write port; they are never active together.
    always_comb begin
        we = 1'b0;
        wa = init_ctr;
        wd = {2'd3, {CSZ{1'b0}}, {ASZ{1'b1}}};
        if (reset_n && (state == S_INIT)) begin
            we = 1'b1;
        end else if (reset_n && dl_vld[LAT]) begin
            we = 1'b1;
            wa = dl_voice[LAT];
            wd = {o_st, o_ctr, o_val};
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wa] <= wd;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n || (state == S_INIT)) begin
            e_st     <= 2'd3;
            e_ctr    <= '0;
            e_val    <= '1;
            e_active <= 1'b0;
            e_trig   <= 1'b0;
        end else if (issue) begin
            {e_st, e_ctr, e_val} <= mem[issue_ctr];
            e_active             <= active[issue_ctr];
            e_trig               <= pend[issue_ctr];
        end else begin
            // Bubble: sustain with rate 0 keeps the engine idle; ctr/val hold last data.
            e_st     <= 2'd2;
            e_active <= 1'b0;
            e_trig   <= 1'b0;
        end
    end

    for (genvar gi = 0; gi < NV; gi++) begin : g_sel
        assign kc_sel[gi] = kc_we && (state == S_RUN) && (kc_voice == VSZ'(gi));
        assign rd_sel[gi] = issue && (issue_ctr == VSZ'(gi));
    end

    // A key-control write to the voice being read wins, so its trigger lands on the next lap.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            active <= '0;
            pend   <= '0;
        end else begin
            for (int i = 0; i < NV; i++) begin
                if (kc_sel[i]) begin
                    active[i] <= kc_on;
                    pend[i]   <= kc_on;
                end else if (rd_sel[i]) begin
                    pend[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            dl_vld <= '0;
        end else begin
            dl_vld <= {dl_vld[LAT-1:0], issue};
        end
    end

    always_ff @(posedge clk) begin
        dl_voice[0] <= issue_ctr;
        for (int k = 1; k <= LAT; k++) begin
            dl_voice[k] <= dl_voice[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            att_vld   <= 1'b0;
            att_voice <= '0;
            atten_out <= '0;
        end else begin
            att_vld <= dl_vld[LAT];
            if (dl_vld[LAT]) begin
                att_voice <= dl_voice[LAT];
                atten_out <= atten;
            end
        end
    end

endmodule

// File: tb/tb_env_state_seq.sv
// Directed bench for env_state_seq with a small LAT-stage engine model in the loop.
module tb_env_state_seq;

    localparam int NV  = 8;
    localparam int VSZ = 3;
    localparam int LAT = 5;
    localparam int CSZ = 15;
    localparam int ASZ = 9;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic           run = 1'b0;
    logic           kc_we = 1'b0;
    logic [VSZ-1:0] kc_voice = '0;
    logic           kc_on = 1'b0;
    logic           e_active, e_trig;
    logic [1:0]     e_st;
    logic [CSZ-1:0] e_ctr;
    logic [ASZ-1:0] e_val;
    logic [1:0]     o_st;
    logic [CSZ-1:0] o_ctr;
    logic [ASZ-1:0] o_val;
    logic [ASZ-1:0] atten;
    logic           att_vld;
    logic [VSZ-1:0] att_voice;
    logic [ASZ-1:0] atten_out;
    logic           busy;

    int errors = 0;
    int checks = 0;
    int n = 0;
    int exp_ctr = 0;
    int pres_v = 0;
    bit toy = 1'b0;
    bit pass_chk = 1'b0;
    bit hist_vld [1024];
    int hist_v [1024];

    logic [25:0] pipe [LAT];

    env_state_seq #(.NV(NV), .VSZ(VSZ), .LAT(LAT), .CSZ(CSZ), .ASZ(ASZ)) dut (
        .clk(clk), .reset_n(reset_n), .run(run),
        .kc_we(kc_we), .kc_voice(kc_voice), .kc_on(kc_on),
        .e_active(e_active), .e_trig(e_trig), .e_st(e_st), .e_ctr(e_ctr), .e_val(e_val),
        .o_st(o_st), .o_ctr(o_ctr), .o_val(o_val), .atten(atten),
        .att_vld(att_vld), .att_voice(att_voice), .atten_out(atten_out), .busy(busy)
    );

    always #5 clk = ~clk;

    // Toy envelope: trigger -> attack (st 0), attack drops val by 256 per visit, then decay -> sustain.
    function automatic logic [25:0] eng(input logic md, input logic act, input logic trg,
                                        input logic [1:0] st, input logic [14:0] ctr,
                                        input logic [8:0] val);
        logic [1:0] ns;
        logic [8:0] nv;
        ns = st;
        nv = val;
        if (md) begin
            if (trg) begin
                ns = 2'd0;
            end else if (!act) begin
                ns = 2'd3;
            end else begin
                case (st)
                    2'd0: begin
                        nv = (val >= 9'd256) ? val - 9'd256 : 9'd0;
                        if (nv == 9'd0) ns = 2'd1;
                    end
                    2'd1: ns = 2'd2;
                    default: ns = st;
                endcase
            end
        end
        return {ns, ctr, nv};
    endfunction

    always @(posedge clk) begin
        pipe[0] <= eng(toy, e_active, e_trig, e_st, e_ctr, e_val);
        for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
    end

    assign {o_st, o_ctr, o_val} = pipe[LAT-1];
    assign atten = pipe[LAT-1][8:0];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_busy"}, busy, 1);
        chk({tag, "_e_st"}, e_st, 3);
        chk({tag, "_e_ctr"}, e_ctr, 0);
        chk({tag, "_e_val"}, e_val, 511);
        chk({tag, "_e_active"}, e_active, 0);
        chk({tag, "_e_trig"}, e_trig, 0);
        chk({tag, "_att_vld"}, att_vld, 0);
        chk({tag, "_att_voice"}, att_voice, 0);
        chk({tag, "_atten_out"}, atten_out, 0);
    endtask

    task automatic wait_init();
        int nb;
        nb = 0;
        while (busy === 1'b1 && nb < 20) begin
            nb++;
            @(posedge clk);
            #1;
            kc_we = 1'b0;
        end
        chk("busy_cycles", nb, 8);
        chk("busy_low", busy, 0);
        n = 0;
        exp_ctr = 0;
    endtask

    // One clock with run=r; checks forward strobe against the run history 6 steps back.
    task automatic cyc(input bit r);
        run = r;
        @(posedge clk);
        #1;
        hist_vld[n] = r;
        hist_v[n] = exp_ctr;
        pres_v = exp_ctr;
        if (r) exp_ctr = (exp_ctr + 1) % NV;
        if (n >= 6) begin
            chk("att_vld", att_vld, hist_vld[n-6]);
            if (hist_vld[n-6]) begin
                chk("att_voice", att_voice, hist_v[n-6]);
                if (pass_chk) chk("atten_out", atten_out, 511);
            end
        end else begin
            chk("att_vld_early", att_vld, 0);
        end
        if (!r) begin
            chk("bubble_st", e_st, 2);
            chk("bubble_active", e_active, 0);
            chk("bubble_trig", e_trig, 0);
        end
        if (n < 1023) n++;
    endtask

    task automatic run_to(input int v);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 16 && !hit; i++) begin
            cyc(1'b1);
            if (pres_v == v) hit = 1'b1;
            else chk("other_trig", e_trig, 0);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("rst");
        reset_n = 1'b1;
        wait_init();

        pass_chk = 1'b1;
        for (int i = 0; i < 16; i++) begin
            cyc(1'b1);
            chk("pt_st", e_st, 3);
            chk("pt_ctr", e_ctr, 0);
            chk("pt_val", e_val, 511);
            chk("pt_active", e_active, 0);
            chk("pt_trig", e_trig, 0);
        end
        pass_chk = 1'b0;
        toy = 1'b1;

        kc_we = 1'b1; kc_voice = 3'd2; kc_on = 1'b1;
        cyc(1'b1);
        kc_we = 1'b0;
        run_to(2);
        chk("v2_lapA_trig", e_trig, 1);
        chk("v2_lapA_active", e_active, 1);
        chk("v2_lapA_st", e_st, 3);
        chk("v2_lapA_val", e_val, 511);
        run_to(2);
        chk("v2_lapB_trig", e_trig, 0);
        chk("v2_lapB_active", e_active, 1);
        chk("v2_lapB_st", e_st, 0);
        chk("v2_lapB_val", e_val, 511);
        run_to(2);
        chk("v2_lapC_st", e_st, 0);
        chk("v2_lapC_val", e_val, 255);
        run_to(2);
        chk("v2_lapD_st", e_st, 1);
        chk("v2_lapD_val", e_val, 0);
        run_to(2);
        chk("v2_lapE_st", e_st, 2);
        chk("v2_lapE_active", e_active, 1);

        kc_we = 1'b1; kc_voice = 3'd2; kc_on = 1'b0;
        cyc(1'b1);
        kc_we = 1'b0;
        run_to(2);
        chk("v2_off_active", e_active, 0);
        chk("v2_off_st", e_st, 2);
        run_to(2);
        chk("v2_rel_st", e_st, 3);
        chk("v2_rel_val", e_val, 0);

        run_to(3);
        kc_we = 1'b1; kc_voice = 3'd4; kc_on = 1'b1;
        cyc(1'b1);
        kc_we = 1'b0;
        chk("v4_coll_trig", e_trig, 0);
        chk("v4_coll_active", e_active, 0);
        run_to(4);
        chk("v4_next_trig", e_trig, 1);
        chk("v4_next_active", e_active, 1);
        chk("v4_next_st", e_st, 3);

        for (int i = 0; i < 24; i++) cyc((i % 2) == 0);
        run_to(4);
        chk("v4_after_alt_st", e_st, 0);
        chk("v4_after_alt_val", e_val, 255);
        chk("v4_after_alt_trig", e_trig, 0);

        run_to(5);
        kc_we = 1'b1; kc_voice = 3'd5; kc_on = 1'b1;
        cyc(1'b1);
        kc_we = 1'b0;
        cyc(1'b1);
        reset_n = 1'b0;
        run = 1'b0;
        @(posedge clk);
        #1;
        chk_reset_vals("midrst");
        reset_n = 1'b1;
        kc_we = 1'b1; kc_voice = 3'd0; kc_on = 1'b1;
        wait_init();

        for (int i = 0; i < 16; i++) begin
            cyc(1'b1);
            chk("post_st", e_st, 3);
            chk("post_ctr", e_ctr, 0);
            chk("post_val", e_val, 511);
            chk("post_active", e_active, 0);
            chk("post_trig", e_trig, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
